// File: rtl/piso_rr_arbiter.sv
// Round-robin arbiter that presents NUM_CH FIFOs to one PISO as a single FIFO, in bursts of up to BURST_LEN words.
// Optional: define PISO_ARB_PRIORITY_EN to let channel 0 win every arbitration it requests.
module piso_rr_arbiter #(
   parameter  int NUM_CH    = 4,
   parameter  int DATA_W    = 16,
   parameter  int BURST_LEN = 4,
   parameter  int HOLD_CYC  = 8,
   localparam int CH_W      = $clog2(NUM_CH)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_CH*DATA_W-1:0] ch_data_i,
   input  logic [NUM_CH-1:0]        ch_empty_i,
   output logic [NUM_CH-1:0]        ch_rd_en_o,
   output logic [DATA_W-1:0]        piso_data_o,
   output logic                     piso_empty_o,
   input  logic                     piso_rd_en_i,
   output logic [CH_W-1:0]          grant_ch_o,
   output logic                     grant_valid_o,
   output logic                     burst_start_o
);

   localparam int WC_W = $clog2(BURST_LEN + 1);
   localparam int EC_W = $clog2(HOLD_CYC + 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t           state_reg, state_next;
   logic [CH_W-1:0]  last_ch_reg, last_ch_next;
   logic [CH_W-1:0]  grant_ch_reg, grant_ch_next;
   logic [WC_W-1:0]  word_cnt_reg, word_cnt_next;
   logic [EC_W-1:0]  empty_cnt_reg, empty_cnt_next;

   logic [DATA_W-1:0] ch_data_arr [NUM_CH];
   logic [CH_W-1:0]   cand_ch     [NUM_CH];
   logic              grant_empty;
   logic              accepted;
   logic              found;
   logic [CH_W-1:0]   pick_ch;

   // cand_ch[k] is the channel at search distance k+1 from the last served one.
   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
         assign ch_data_arr[gi] = ch_data_i[gi*DATA_W +: DATA_W];
         assign cand_ch[gi]     = CH_W'((int'(last_ch_reg) + gi + 1) % NUM_CH);
         assign ch_rd_en_o[gi]  = accepted && (grant_ch_reg == CH_W'(gi));
      end
   endgenerate

   assign grant_empty = ch_empty_i[grant_ch_reg];
   assign accepted    = (state_reg == GRANT) && piso_rd_en_i && !grant_empty;

   // Walk from the farthest candidate to the nearest so the nearest non-empty one wins.
   always_comb begin
      found   = 1'b0;
      pick_ch = last_ch_reg;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (!ch_empty_i[cand_ch[i]]) begin
            found   = 1'b1;
            pick_ch = cand_ch[i];
         end
      end
`ifdef PISO_ARB_PRIORITY_EN
      if (!ch_empty_i[0]) begin
         found   = 1'b1;
         pick_ch = '0;
      end
`endif
   end

   always_comb begin
      state_next     = state_reg;
      last_ch_next   = last_ch_reg;
      grant_ch_next  = grant_ch_reg;
      word_cnt_next  = word_cnt_reg;
      empty_cnt_next = empty_cnt_reg;
      case (state_reg)
         IDLE: begin
            if (found) begin
               state_next     = GRANT;
               grant_ch_next  = pick_ch;
               word_cnt_next  = '0;
               empty_cnt_next = '0;
            end
         end
         GRANT: begin
            if (accepted) begin
               word_cnt_next = word_cnt_reg + WC_W'(1);
            end
            if (grant_empty) begin
               empty_cnt_next = empty_cnt_reg + EC_W'(1);
            end else begin
               empty_cnt_next = '0;
            end
            if (accepted && (word_cnt_reg == WC_W'(BURST_LEN - 1))) begin
               state_next   = IDLE;
               last_ch_next = grant_ch_reg;
            end else if (grant_empty && (empty_cnt_reg == EC_W'(HOLD_CYC - 1))) begin
               state_next   = IDLE;
               last_ch_next = grant_ch_reg;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         last_ch_reg   <= CH_W'(NUM_CH - 1);
         grant_ch_reg  <= '0;
         word_cnt_reg  <= '0;
         empty_cnt_reg <= '0;
      end else begin
         state_reg     <= state_next;
         last_ch_reg   <= last_ch_next;
         grant_ch_reg  <= grant_ch_next;
         word_cnt_reg  <= word_cnt_next;
         empty_cnt_reg <= empty_cnt_next;
      end
   end

   assign piso_data_o   = (state_reg == GRANT) ? ch_data_arr[grant_ch_reg] : '0;
   assign piso_empty_o  = (state_reg == GRANT) ? grant_empty : 1'b1;
   assign grant_valid_o = (state_reg == GRANT);
   assign grant_ch_o    = grant_ch_reg;
   assign burst_start_o = accepted && (word_cnt_reg == '0);

endmodule

// File: tb/tb_piso_rr_arbiter.sv
// Directed bench for piso_rr_arbiter: modelled upstream FIFOs, a per-cycle monitor, and hand-computed grant/burst expectations.
module tb_piso_rr_arbiter;

   localparam int NUM_CH = 4;
   localparam int DATA_W = 16;
   localparam int INF    = -1;

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b0;
   logic [NUM_CH*DATA_W-1:0] ch_data_i;
   logic [NUM_CH-1:0]        ch_empty_i;
   logic [NUM_CH-1:0]        ch_rd_en_o;
   logic [DATA_W-1:0]        piso_data_o;
   logic                     piso_empty_o;
   logic                     piso_rd_en_i;
   logic [1:0]               grant_ch_o;
   logic                     grant_valid_o;
   logic                     burst_start_o;

   always #5 clk = ~clk;

   piso_rr_arbiter #(
      .NUM_CH   (NUM_CH),
      .DATA_W   (DATA_W),
      .BURST_LEN(4),
      .HOLD_CYC (8)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ch_data_i    (ch_data_i),
      .ch_empty_i   (ch_empty_i),
      .ch_rd_en_o   (ch_rd_en_o),
      .piso_data_o  (piso_data_o),
      .piso_empty_o (piso_empty_o),
      .piso_rd_en_i (piso_rd_en_i),
      .grant_ch_o   (grant_ch_o),
      .grant_valid_o(grant_valid_o),
      .burst_start_o(burst_start_o)
   );

   int              n_tests = 0;
   int              n_fail  = 0;
   int              fifo_cnt [NUM_CH];
   logic [15:0]     model_data [NUM_CH] = '{16'hAAAA, 16'h5555, 16'hFFFF, 16'h0000};
   logic [NUM_CH-1:0] rd_saved = '0;

   int   grants[$];
   int   lens[$];
   int   gaps[$];
   int   rd_count [NUM_CH];
   int   starts, stray, empty_grant, idle_data_bad, onehot_bad, idle_run, cur_len;
   logic prev_valid;
   bit   had_grant;

   int   exp_rr   [5] = '{0, 1, 2, 3, 0};
   int   exp_pri  [4];

   task automatic check_eq(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   task automatic drive_empty();
      for (int c = 0; c < NUM_CH; c++) ch_empty_i[c] = (fifo_cnt[c] == 0);
   endtask

   task automatic clear_mon();
      grants.delete();
      lens.delete();
      gaps.delete();
      for (int c = 0; c < NUM_CH; c++) rd_count[c] = 0;
      starts = 0; stray = 0; empty_grant = 0; idle_data_bad = 0; onehot_bad = 0;
      idle_run = 0; cur_len = 0; prev_valid = 1'b0; had_grant = 1'b0;
   endtask

   // One clock: FIFOs pop just after the edge on last cycle's strobes, outputs sampled on the falling edge.
   task automatic step();
      @(posedge clk);
      #1;
      for (int c = 0; c < NUM_CH; c++)
         if (rd_saved[c] && fifo_cnt[c] > 0) fifo_cnt[c]--;
      drive_empty();
      @(negedge clk);
      rd_saved = ch_rd_en_o;
      if ($countones(ch_rd_en_o) > 1) onehot_bad++;
      if (ch_rd_en_o != '0 && (!grant_valid_o || piso_empty_o)) stray++;
      if (!grant_valid_o && piso_data_o != '0) idle_data_bad++;
      if (burst_start_o) starts++;
      if (grant_valid_o && piso_empty_o) empty_grant++;
      if (grant_valid_o && !prev_valid) begin
         if (had_grant) gaps.push_back(idle_run);
         grants.push_back(int'(grant_ch_o));
         had_grant = 1'b1;
         cur_len   = 0;
         idle_run  = 0;
      end
      if (!grant_valid_o && prev_valid) lens.push_back(cur_len);
      if (!grant_valid_o) idle_run++;
      for (int c = 0; c < NUM_CH; c++) begin
         if (ch_rd_en_o[c]) begin
            rd_count[c]++;
            cur_len++;
            $display("[TB] t=%0t read ch%0d data=%h start=%0b", $time, c, piso_data_o, burst_start_o);
            check_eq("rd_data", int'(piso_data_o), int'(model_data[c]));
            check_eq("rd_grant", int'(grant_ch_o), c);
         end
      end
      prev_valid = grant_valid_o;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) step();
      clear_mon();
      rd_saved = '0;
      rst_n = 1'b1;
   endtask

   task automatic check_reset_outputs(input string pfx);
      check_eq({pfx, "_rd_en"},   int'(ch_rd_en_o), 0);
      check_eq({pfx, "_data"},    int'(piso_data_o), 0);
      check_eq({pfx, "_empty"},   int'(piso_empty_o), 1);
      check_eq({pfx, "_grant"},   int'(grant_ch_o), 0);
      check_eq({pfx, "_valid"},   int'(grant_valid_o), 0);
      check_eq({pfx, "_bstart"},  int'(burst_start_o), 0);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
`ifdef PISO_ARB_PRIORITY_EN
      exp_pri = '{0, 0, 0, 0};
`else
      exp_pri = '{0, 3, 0, 3};
`endif
      ch_data_i    = {model_data[3], model_data[2], model_data[1], model_data[0]};
      piso_rd_en_i = 1'b1;
      clear_mon();

      // Reset values with every channel requesting and the PISO strobing
      for (int c = 0; c < NUM_CH; c++) fifo_cnt[c] = INF;
      drive_empty();
      rst_n = 1'b0;
      step();
      check_reset_outputs("rst");

      // Only ch2 holds 4 words
      fifo_cnt = '{0, 0, 4, 0};
      drive_empty();
      do_reset();
      repeat (10) step();
      check_eq("t1_ngrants", grants.size(), 1);
      check_eq("t1_grant", (grants.size() > 0) ? grants[0] : -1, 2);
      check_eq("t1_reads2", rd_count[2], 4);
      check_eq("t1_reads_other", rd_count[0] + rd_count[1] + rd_count[3], 0);
      check_eq("t1_starts", starts, 1);
      check_eq("t1_len", (lens.size() > 0) ? lens[0] : -1, 4);
      check_eq("t1_valid_end", int'(grant_valid_o), 0);
      check_eq("t1_empty_end", int'(piso_empty_o), 1);
      check_eq("t1_grant_hold", int'(grant_ch_o), 2);
      repeat (4) step();
      check_eq("t1_stray", stray, 0);
      check_eq("t1_idle_data", idle_data_bad, 0);

      // All channels always non-empty: rotation with one dead cycle
      for (int c = 0; c < NUM_CH; c++) fifo_cnt[c] = INF;
      drive_empty();
      do_reset();
      repeat (21) step();
      check_eq("t2_ngrants", grants.size(), 5);
      for (int i = 0; i < 5; i++)
         check_eq($sformatf("t2_grant%0d", i), (i < grants.size()) ? grants[i] : -1, exp_rr[i]);
      check_eq("t2_nlens", lens.size(), 4);
      for (int i = 0; i < 4; i++)
         check_eq($sformatf("t2_len%0d", i), (i < lens.size()) ? lens[i] : -1, 4);
      check_eq("t2_ngaps", gaps.size(), 4);
      for (int i = 0; i < 4; i++)
         check_eq($sformatf("t2_gap%0d", i), (i < gaps.size()) ? gaps[i] : -1, 1);
      check_eq("t2_starts", starts, 5);
      check_eq("t2_onehot", onehot_bad, 0);

      // ch1 runs dry after 2 words and is held for 8 empty cycles before ch2 gets its turn
      fifo_cnt = '{0, 2, INF, 0};
      drive_empty();
      do_reset();
      repeat (16) step();
      check_eq("t3_ngrants", grants.size(), 2);
      check_eq("t3_grant0", (grants.size() > 0) ? grants[0] : -1, 1);
      check_eq("t3_grant1", (grants.size() > 1) ? grants[1] : -1, 2);
      check_eq("t3_len0", (lens.size() > 0) ? lens[0] : -1, 2);
      check_eq("t3_len1", (lens.size() > 1) ? lens[1] : -1, 4);
      check_eq("t3_hold_cycles", empty_grant, 8);
      check_eq("t3_gap", (gaps.size() > 0) ? gaps[0] : -1, 1);
      check_eq("t3_starts", starts, 2);
      check_eq("t3_stray", stray, 0);

      // Asynchronous reset in the middle of a ch3 burst
      fifo_cnt = '{0, 0, 0, INF};
      drive_empty();
      do_reset();
      repeat (3) step();
      check_eq("t4_pre_valid", int'(grant_valid_o), 1);
      check_eq("t4_pre_grant", int'(grant_ch_o), 3);
      check_eq("t4_pre_rd", int'(ch_rd_en_o), 8);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("t4_async");
      for (int c = 0; c < NUM_CH; c++) fifo_cnt[c] = INF;
      drive_empty();
      do_reset();
      step();
      check_eq("t4_post_valid", int'(grant_valid_o), 1);
      check_eq("t4_post_grant", int'(grant_ch_o), 0);
      check_eq("t4_post_bstart", int'(burst_start_o), 1);

      // ch0 and ch3 always requesting
      fifo_cnt = '{INF, 0, 0, INF};
      drive_empty();
      do_reset();
      repeat (20) step();
      check_eq("t6_ngrants", grants.size(), 4);
      for (int i = 0; i < 4; i++)
         check_eq($sformatf("t6_grant%0d", i), (i < grants.size()) ? grants[i] : -1, exp_pri[i]);
      check_eq("t6_onehot", onehot_bad, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/piso_rr_arbiter.md
# piso_rr_arbiter

Round-robin arbiter that shares one `piso` serializer between `NUM_CH` input FIFOs feeding the Viterbi decoder path. To the PISO it looks like a single FIFO: `piso_data_o`, `piso_empty_o`, `piso_rd_en_i`. It grants one channel at a time for a burst of up to `BURST_LEN` 16-bit words. It reports the granted channel so downstream logic can tag the 2-bit symbol stream per channel.

## Interface
- `NUM_CH`, 4: number of requesting FIFOs, 2..8.
- `DATA_W`, 16: FIFO word width; must match the PISO input.
- `BURST_LEN`, 4: maximum words read per grant, ≥1.
- `HOLD_CYC`, 8: consecutive empty cycles of the granted channel before the grant is released, ≥1.
- `CH_W`, `$clog2(NUM_CH)`: derived; width of the channel index.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ch_data_i`  in  `NUM_CH*DATA_W`  FIFO read data; channel c occupies `[c*DATA_W +: DATA_W]`.
- `ch_empty_i`  in  `NUM_CH`  FIFO empty flags.
- `ch_rd_en_o`  out  `NUM_CH`  FIFO read strobes; at most one bit is high.
- `piso_data_o`  out  `DATA_W`  data of the granted channel.
- `piso_empty_o`  out  1  empty flag presented to the PISO.
- `piso_rd_en_i`  in  1  read strobe from the PISO.
- `grant_ch_o`  out  `CH_W`  index of the currently or last granted channel.
- `grant_valid_o`  out  1  high while in GRANT.
- `burst_start_o`  out  1  one-cycle pulse on the first accepted read of a burst.

## Operation
- FSM has two states, IDLE and GRANT. Reset state is IDLE.
- IDLE:
  - Search `ch_empty_i` round-robin, starting at `last_ch+1` and wrapping modulo `NUM_CH`.
  - If a non-empty channel is found, register it into `grant_ch_o`, clear `word_cnt` and `empty_cnt`, and go to GRANT.
  - If no channel is non-empty, stay in IDLE.
- GRANT:
  - `piso_data_o` = data of the granted channel.
  - `piso_empty_o` = `ch_empty_i[grant]`.
- Accepted read: `piso_rd_en_i & ~ch_empty_i[grant]` in GRANT. On an accepted read:
  - `ch_rd_en_o[grant]` = 1 in that same cycle (combinational pass-through).
  - `word_cnt` increments.
- A strobe that is not an accepted read is ignored: no FIFO strobe, no count change. This covers a strobe in IDLE or a strobe while the granted channel is empty.
- `burst_start_o` = accepted read & (`word_cnt` == 0).
- Release on burst completion: an accepted read with `word_cnt == BURST_LEN-1` → IDLE next cycle, and `last_ch` ← grant.
- Release on starvation: `empty_cnt` counts consecutive GRANT cycles with `ch_empty_i[grant]` = 1 and resets on any non-empty cycle. When `empty_cnt == HOLD_CYC-1` with the channel still empty → IDLE, and `last_ch` ← grant.
- If both release conditions hold in the same cycle, burst completion wins; the result is identical anyway.
- `word_cnt` is `$clog2(BURST_LEN+1)` bits wide and `empty_cnt` is `$clog2(HOLD_CYC+1)` bits wide. Neither counter wraps: both are cleared on entry to GRANT.
- In IDLE:
  - `piso_empty_o` = 1.
  - `piso_data_o` = 0.
  - `grant_valid_o` = 0.
  - `grant_ch_o` holds its last value.

## Timing
- Reset values: `last_ch` = `NUM_CH-1`, so channel 0 is searched first. All outputs during reset:
  - `ch_rd_en_o` = 0.
  - `piso_data_o` = 0.
  - `piso_empty_o` = 1.
  - `grant_ch_o` = 0.
  - `grant_valid_o` = 0.
  - `burst_start_o` = 0.
- Reset mid-burst: outputs go to these values immediately (asynchronous). A word already strobed out of a FIFO is lost; recovery is the upstream's responsibility.
- Arbitration latency: a channel that is non-empty at edge N is granted after edge N, so `piso_empty_o` falls in cycle N+1.
- Every release spends at least one cycle in IDLE. Back-to-back bursts from different channels therefore have exactly one dead cycle.
- `ch_rd_en_o`, `piso_data_o` and `piso_empty_o` are combinational from the grant register and the inputs. No extra read latency is added: the PISO's FIFO timing is preserved.

## Configuration
- `PISO_ARB_PRIORITY_EN` defined: in IDLE, channel 0 wins whenever it is non-empty, regardless of `last_ch`. All other channels are arbitrated round-robin as above. Intended for the control/sync channel.
- `PISO_ARB_PRIORITY_EN` undefined: pure round-robin; channel 0 has no precedence.

## Test plan
- Only ch2 non-empty, holding 4 words, `BURST_LEN`=4 → `grant_ch_o`=2, exactly 4 `ch_rd_en_o[2]` pulses, `burst_start_o` on the first, IDLE afterwards with `piso_empty_o`=1.
- All 4 channels continuously non-empty with distinct data (16'hAAAA, 16'h5555, 16'hFFFF, 16'h0000) → grant order 0,1,2,3,0, exactly 4 reads each, one dead cycle between bursts, each channel's data seen on `piso_data_o`.
- ch1 empties after 2 words, `HOLD_CYC`=8, ch2 non-empty → grant stays on ch1 for 8 empty cycles, then IDLE, then ch2 is granted with `word_cnt` restarted.
- `rst_n` dropped mid-burst on ch3 → all outputs take their reset values in the same cycle; after release with all channels non-empty, ch0 is granted first.
- `piso_rd_en_i` held at 1 in IDLE and while the granted channel is empty → `ch_rd_en_o` stays 0 and no word is counted.
- `PISO_ARB_PRIORITY_EN` defined, ch0 and ch3 always non-empty → ch0 granted on every arbitration; without the macro, ch0 and ch3 alternate.
